// File: rtl/ebus_pkg.sv
// Shared EBUS diagnostic definitions.
// Contents:
//   - EbusWidth / EbusDsWidth: EBUS data word and diag function select widths.
//   - ebus_word_t: one EBUS data word. Bit 0 is the MSB.
//   - diag_function_e: the group decoded from the function select.
//   - DsReadGroupBit: the ds bit that selects the read group.
//   - diag_rx_state_e: receiver FSM states.
//   - TimeoutData: the word driven when a read times out.
//   - odd_parity(): returns the bit that makes the total count of ones in a word odd.
package ebus_pkg;

    localparam int unsigned EbusWidth      = 36;
    localparam int unsigned EbusDsWidth    = 7;
    localparam int unsigned DsReadGroupBit = 0;

    typedef logic [0:EbusWidth-1] ebus_word_t;

    localparam ebus_word_t TimeoutData = '1;

    typedef enum logic {
        FuncWrite = 1'b0,
        FuncRead  = 1'b1
    } diag_function_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWrHold  = 3'd1,
        StRdWait  = 3'd2,
        StRdDrive = 3'd3,
        StStbLow  = 3'd4
    } diag_rx_state_e;

    function automatic logic odd_parity(input ebus_word_t w);
        return ~^w;
    endfunction

endpackage

// File: rtl/ebus_diag_timeout.sv
// Read-acknowledge timeout counter.
// The counter is a loadable, saturating up-counter. It never wraps.
// Ports:
//   clk_i   EBUS clock.
//   rst_i   Asynchronous, active-high reset.
//   load_i  Clears the count to 0. This takes priority over en_i.
//   en_i    Advances the count by one. The count stops at Ticks-1.
//   done_o  High while the count equals Ticks-1.
module ebus_diag_timeout #(
    parameter int unsigned Ticks = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CntW = (Ticks > 1) ? $clog2(Ticks) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Ticks - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Last)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == Last);

endmodule

// File: rtl/ebus_diag_receiver.sv
// EBUS-side consumer of the diagnostic cycles that the front-end DTE drives.
//
// Operation:
//   - A rising edge of the diag strobe latches ds and the EBUS data.
//   - Write-group cycles (ds[0]=0):
//       - func_pulse_o pulses for one cycle.
//       - wr_data_o is handed to the target through a valid/ready handshake.
//   - Read-group cycles (ds[0]=1):
//       - rd_req_o is raised and held until rd_ack_i.
//       - The returned word is then driven onto EBUS until the strobe drops.
//       - If the target never acknowledges, the all-ones word is driven instead.
//
// Build option:
//   EBUS_PARITY_EN adds these ports:
//     - ebus_parity_o: odd parity of ebus_data_o.
//     - ebus_parity_i: parity from the DTE, checked against the write data.
//     - parity_err_o:  sticky write-data parity error.
//
// Ports:
//   clk_i, rst_i                  Clock, and an asynchronous active-high reset.
//   diag_strobe_i, ds_i           DTE diag strobe and function code.
//   ebus_data_i                   Write data from the DTE.
//   ebus_drive_o, ebus_data_o     Read data onto EBUS. ebus_data_o is 0 when not driving.
//   func_pulse_o, func_code_o     Write-group pulse, and the latched function code.
//   wr_valid_o, wr_data_o,
//   wr_ready_i                    Write handshake to the target.
//   rd_req_o, rd_ack_i,
//   rd_data_i                     Read handshake to the target.
//   overrun_o                     Sticky. A new strobe arrived while a write was still undrained.
//   timeout_err_o                 Sticky. A read was not acknowledged in time.
module ebus_diag_receiver
    import ebus_pkg::*;
#(
    parameter int unsigned TimeoutTicks = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   diag_strobe_i,
    input  logic [0:EbusDsWidth-1] ds_i,
    input  ebus_word_t             ebus_data_i,
    output logic                   ebus_drive_o,
    output ebus_word_t             ebus_data_o,
    output logic                   func_pulse_o,
    output logic [0:EbusDsWidth-1] func_code_o,
    output logic                   wr_valid_o,
    output ebus_word_t             wr_data_o,
    input  logic                   wr_ready_i,
    output logic                   rd_req_o,
    input  logic                   rd_ack_i,
    input  ebus_word_t             rd_data_i,
    output logic                   overrun_o,
    output logic                   timeout_err_o
`ifdef EBUS_PARITY_EN
    ,
    output logic                   ebus_parity_o,
    input  logic                   ebus_parity_i,
    output logic                   parity_err_o
`endif
);

    diag_rx_state_e         state_q, state_d;
    logic                   strobe_q;
    logic [0:EbusDsWidth-1] func_code_q, func_code_d;
    ebus_word_t             wr_data_q, wr_data_d;
    logic                   wr_valid_q, wr_valid_d;
    logic                   func_pulse_q, func_pulse_d;
    logic                   rd_req_q, rd_req_d;
    logic                   drive_q, drive_d;
    ebus_word_t             data_out_q, data_out_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_err_q, timeout_err_d;
`ifdef EBUS_PARITY_EN
    logic                   parity_q, parity_d;
    logic                   parity_err_q, parity_err_d;
`endif

    logic           stb_edge;
    diag_function_e grp;
    logic           tmr_load, tmr_en, tmr_done;

    // Only a 0->1 transition starts a cycle. A strobe that stays high is ignored.
    assign stb_edge = diag_strobe_i & ~strobe_q;
    assign grp      = diag_function_e'(ds_i[DsReadGroupBit]);

    ebus_diag_timeout #(
        .Ticks (TimeoutTicks)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d       = state_q;
        func_code_d   = func_code_q;
        wr_data_d     = wr_data_q;
        wr_valid_d    = wr_valid_q;
        func_pulse_d  = 1'b0;
        rd_req_d      = rd_req_q;
        drive_d       = drive_q;
        data_out_d    = data_out_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        tmr_load      = 1'b0;
        tmr_en        = 1'b0;
`ifdef EBUS_PARITY_EN
        parity_err_d  = parity_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (stb_edge) begin
                    func_code_d = ds_i;
                    wr_data_d   = ebus_data_i;
                    if (grp == FuncRead) begin
                        rd_req_d = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = StRdWait;
                    end else begin
                        func_pulse_d = 1'b1;
                        wr_valid_d   = 1'b1;
                        state_d      = StWrHold;
`ifdef EBUS_PARITY_EN
                        if (odd_parity(ebus_data_i) != ebus_parity_i) begin
                            parity_err_d = 1'b1;
                        end
`endif
                    end
                end
            end
            StWrHold: begin
                // A second cycle cannot be accepted until the write drains. It is dropped and flagged.
                if (stb_edge) begin
                    overrun_d = 1'b1;
                end
                if (wr_valid_q && wr_ready_i) begin
                    wr_valid_d = 1'b0;
                    state_d    = diag_strobe_i ? StStbLow : StIdle;
                end
            end
            StRdWait: begin
                tmr_en = 1'b1;
                if (!diag_strobe_i) begin
                    rd_req_d = 1'b0;
                    state_d  = StIdle;
                end else if (rd_ack_i) begin
                    // The acknowledge is checked before the timeout, so a same-cycle ack is not an error.
                    rd_req_d   = 1'b0;
                    drive_d    = 1'b1;
                    data_out_d = rd_data_i;
                    state_d    = StRdDrive;
                end else if (tmr_done) begin
                    rd_req_d      = 1'b0;
                    drive_d       = 1'b1;
                    data_out_d    = TimeoutData;
                    timeout_err_d = 1'b1;
                    state_d       = StRdDrive;
                end
            end
            StRdDrive: begin
                if (!diag_strobe_i) begin
                    drive_d    = 1'b0;
                    data_out_d = '0;
                    state_d    = StIdle;
                end
            end
            StStbLow: begin
                if (!diag_strobe_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef EBUS_PARITY_EN
        parity_d = drive_d ? odd_parity(data_out_d) : 1'b0;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            strobe_q      <= 1'b0;
            func_code_q   <= '0;
            wr_data_q     <= '0;
            wr_valid_q    <= 1'b0;
            func_pulse_q  <= 1'b0;
            rd_req_q      <= 1'b0;
            drive_q       <= 1'b0;
            data_out_q    <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef EBUS_PARITY_EN
            parity_q      <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            strobe_q      <= diag_strobe_i;
            func_code_q   <= func_code_d;
            wr_data_q     <= wr_data_d;
            wr_valid_q    <= wr_valid_d;
            func_pulse_q  <= func_pulse_d;
            rd_req_q      <= rd_req_d;
            drive_q       <= drive_d;
            data_out_q    <= data_out_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
`ifdef EBUS_PARITY_EN
            parity_q      <= parity_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign ebus_drive_o  = drive_q;
    // EBUS is wired-OR, so this block must present zeros whenever it is not driving.
    assign ebus_data_o   = drive_q ? data_out_q : '0;
    assign func_pulse_o  = func_pulse_q;
    assign func_code_o   = func_code_q;
    assign wr_valid_o    = wr_valid_q;
    assign wr_data_o     = wr_data_q;
    assign rd_req_o      = rd_req_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_err_q;
`ifdef EBUS_PARITY_EN
    assign ebus_parity_o = parity_q;
    assign parity_err_o  = parity_err_q;
`endif

endmodule

// File: tb/tb_ebus_diag_receiver.sv
// Directed bench for ebus_diag_receiver.
// Inputs change 1 time unit after each rising clock edge. Outputs are sampled at that same point.
module tb_ebus_diag_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        diag_strobe;
    logic [0:6]  ds;
    logic [0:35] ebus_data_in;
    logic        ebus_drive;
    logic [0:35] ebus_data_out;
    logic        func_pulse;
    logic [0:6]  func_code;
    logic        wr_valid;
    logic [0:35] wr_data;
    logic        wr_ready;
    logic        rd_req;
    logic        rd_ack;
    logic [0:35] rd_data;
    logic        overrun;
    logic        timeout_err;
`ifdef EBUS_PARITY_EN
    logic        ebus_parity;
    logic        ebus_parity_in;
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int hs_base;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid && wr_ready) hs_cnt <= hs_cnt + 1;
    end

    ebus_diag_receiver #(
        .TimeoutTicks (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .diag_strobe_i (diag_strobe),
        .ds_i          (ds),
        .ebus_data_i   (ebus_data_in),
        .ebus_drive_o  (ebus_drive),
        .ebus_data_o   (ebus_data_out),
        .func_pulse_o  (func_pulse),
        .func_code_o   (func_code),
        .wr_valid_o    (wr_valid),
        .wr_data_o     (wr_data),
        .wr_ready_i    (wr_ready),
        .rd_req_o      (rd_req),
        .rd_ack_i      (rd_ack),
        .rd_data_i     (rd_data),
        .overrun_o     (overrun),
        .timeout_err_o (timeout_err)
`ifdef EBUS_PARITY_EN
        ,
        .ebus_parity_o (ebus_parity),
        .ebus_parity_i (ebus_parity_in),
        .parity_err_o  (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %o, expected %o", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst          = 1'b1;
        diag_strobe  = 1'b0;
        ds           = '0;
        ebus_data_in = '0;
        wr_ready     = 1'b0;
        rd_ack       = 1'b0;
        rd_data      = '0;
`ifdef EBUS_PARITY_EN
        ebus_parity_in = 1'b0;
`endif
        step(2);
        chk("rst_drive", ebus_drive, 0);
        chk("rst_data", ebus_data_out, 0);
        chk("rst_pulse", func_pulse, 0);
        chk("rst_code", func_code, 0);
        chk("rst_wrvalid", wr_valid, 0);
        chk("rst_rdreq", rd_req, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        step(1);

        // Test 1: simple write with the target always ready.
        hs_base      = hs_cnt;
        diag_strobe  = 1'b1;
        ds           = 7'o042;
        ebus_data_in = 36'o123456_654321;
        wr_ready     = 1'b1;
        step(1);
        chk("w1_pulse", func_pulse, 1);
        chk("w1_valid", wr_valid, 1);
        chk("w1_data", wr_data, 36'o123456_654321);
        chk("w1_code", func_code, 7'o042);
        chk("w1_nodrive", ebus_drive, 0);
        step(1);
        chk("w1_pulse_off", func_pulse, 0);
        chk("w1_valid_off", wr_valid, 0);
        chk("w1_hs", hs_cnt - hs_base, 1);
        step(2);
        chk("w1_held_nopulse", func_pulse, 0);
        diag_strobe = 1'b0;
        wr_ready    = 1'b0;
        step(2);

        // Test 2: write under backpressure, with a second strobe edge while the first write waits.
        hs_base      = hs_cnt;
        diag_strobe  = 1'b1;
        ds           = 7'o042;
        ebus_data_in = 36'o111111_222222;
        step(1);
        chk("w2_valid", wr_valid, 1);
        chk("w2_pulse", func_pulse, 1);
        step(3);
        chk("w2_valid_held", wr_valid, 1);
        chk("w2_pulse_once", func_pulse, 0);
        diag_strobe = 1'b0;
        step(2);
        chk("w2_valid_after_drop", wr_valid, 1);
        chk("w2_no_overrun_yet", overrun, 0);
        diag_strobe  = 1'b1;
        ebus_data_in = 36'o333333_444444;
        step(1);
        chk("w2_overrun", overrun, 1);
        chk("w2_valid_2nd", wr_valid, 1);
        chk("w2_data_kept", wr_data, 36'o111111_222222);
        chk("w2_no_pulse_2nd", func_pulse, 0);
        step(3);
        wr_ready = 1'b1;
        step(1);
        chk("w2_valid_done", wr_valid, 0);
        step(2);
        chk("w2_valid_stays_low", wr_valid, 0);
        chk("w2_hs_once", hs_cnt - hs_base, 1);
        diag_strobe = 1'b0;
        wr_ready    = 1'b0;
        step(2);
        chk("w2_overrun_sticky", overrun, 1);

        // Test 3: read acknowledged after 3 cycles.
        diag_strobe = 1'b1;
        ds          = 7'o101;
        step(1);
        chk("r3_req", rd_req, 1);
        chk("r3_code", func_code, 7'o101);
        chk("r3_nodrive", ebus_drive, 0);
        step(2);
        rd_ack  = 1'b1;
        rd_data = 36'o777000_000777;
        step(1);
        rd_ack  = 1'b0;
        rd_data = '0;
        chk("r3_drive", ebus_drive, 1);
        chk("r3_data", ebus_data_out, 36'o777000_000777);
        chk("r3_req_off", rd_req, 0);
        step(3);
        chk("r3_drive_held", ebus_drive, 1);
        chk("r3_data_held", ebus_data_out, 36'o777000_000777);
        diag_strobe = 1'b0;
        step(1);
        chk("r3_release_drive", ebus_drive, 0);
        chk("r3_release_data", ebus_data_out, 0);
        chk("r3_no_timeout", timeout_err, 0);
        step(1);

        // Test 4: read with no acknowledge, so the timeout fires.
        diag_strobe = 1'b1;
        ds          = 7'o170;
        step(1);
        chk("t4_req", rd_req, 1);
        step(15);
        chk("t4_not_yet", ebus_drive, 0);
        chk("t4_req_still", rd_req, 1);
        chk("t4_err_not_yet", timeout_err, 0);
        step(1);
        chk("t4_drive", ebus_drive, 1);
        chk("t4_ones", ebus_data_out, 36'o777777_777777);
        chk("t4_err", timeout_err, 1);
        chk("t4_req_off", rd_req, 0);
        diag_strobe = 1'b0;
        step(1);
        chk("t4_release", ebus_drive, 0);
        chk("t4_err_sticky", timeout_err, 1);
        step(1);

        // Test 5a: the strobe drops during the read wait, and a late ack arrives afterwards.
        diag_strobe = 1'b1;
        ds          = 7'o101;
        step(3);
        diag_strobe = 1'b0;
        step(1);
        chk("a5_req_off", rd_req, 0);
        chk("a5_nodrive", ebus_drive, 0);
        rd_ack  = 1'b1;
        rd_data = 36'o525252_525252;
        step(2);
        chk("a5_late_ack_ignored", ebus_drive, 0);
        chk("a5_late_data_zero", ebus_data_out, 0);
        rd_ack = 1'b0;

        // Test 5b: rd_ack is already high at the edge, giving a 2-cycle edge-to-drive latency.
        // A reset then arrives while the block is driving.
        diag_strobe = 1'b1;
        rd_ack      = 1'b1;
        rd_data     = 36'o000123_000456;
        step(1);
        chk("a5_min_nodrive", ebus_drive, 0);
        chk("a5_min_req", rd_req, 1);
        step(1);
        rd_ack = 1'b0;
        chk("a5_min_drive", ebus_drive, 1);
        chk("a5_min_data", ebus_data_out, 36'o000123_000456);
        #2;
        rst = 1'b1;
        #1;
        chk("a5_rst_drive", ebus_drive, 0);
        chk("a5_rst_data", ebus_data_out, 0);
        chk("a5_rst_timeout", timeout_err, 0);
        chk("a5_rst_overrun", overrun, 0);
        chk("a5_rst_code", func_code, 0);
        diag_strobe = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);
        chk("a5_idle_after_rst", ebus_drive, 0);

`ifdef EBUS_PARITY_EN
        // Test 6: parity of the driven data, and a bad parity input on a write.
        diag_strobe = 1'b1;
        ds          = 7'o101;
        step(1);
        chk("p6_nodrive_parity", ebus_parity, 0);
        rd_ack  = 1'b1;
        rd_data = 36'o000000_000001;
        step(1);
        rd_ack = 1'b0;
        chk("p6_drive", ebus_drive, 1);
        chk("p6_parity", ebus_parity, 0);
        diag_strobe = 1'b0;
        step(2);
        diag_strobe    = 1'b1;
        ds             = 7'o042;
        ebus_data_in   = '0;
        ebus_parity_in = 1'b0;
        wr_ready       = 1'b1;
        step(1);
        chk("p6_parity_err", parity_err, 1);
        diag_strobe = 1'b0;
        wr_ready    = 1'b0;
        step(2);
        chk("p6_parity_err_sticky", parity_err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
